// File: rtl/flipflop_pkg.sv
// Shared encodings and widths for the down-counter sequence checker.
package flipflop_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
    import flipflop_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/down_count_checker.sv
// Observes a free-running down counter and reports lock, sequence errors and wraps.
//   state      | meaning
//   ST_ACQUIRE | counting consecutive good transitions toward lock
//   ST_LOCKED  | sequence trusted; bad step -> seq_err, good 0->max -> wrap
//   ST_FAULT   | error limit reached; frozen until rst
module down_count_checker
    import flipflop_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int LOCK_N    = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    output logic             locked,
    output logic             fault,
    output logic             seq_err,
    output logic             wrap,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt
);

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic             r_have_prev;
    logic [3:0]       r_run;
    logic             r_locked;
    logic             r_fault;
    logic             r_seq_err;
    logic             r_wrap;

    logic             w_good;
    logic             w_err_evt;
    logic             w_wrap_evt;
    logic [CNT_W-1:0] w_err_next;
    logic [3:0]       w_run_inc;

    assign w_good     = r_have_prev && (count == (r_prev - WIDTH'(1)));
    assign w_err_evt  = (r_state == ST_LOCKED) && !w_good;
    assign w_wrap_evt = (r_state == ST_LOCKED) && w_good && (r_prev == '0);
    // Error tally as it will read after this edge, used for the fault decision.
    assign w_err_next = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
    assign w_run_inc  = r_run + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACQUIRE;
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_run       <= '0;
            r_locked    <= 1'b0;
            r_fault     <= 1'b0;
            r_seq_err   <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_prev      <= count;
            r_have_prev <= 1'b1;
            r_seq_err   <= 1'b0;
            r_wrap      <= 1'b0;
            case (r_state)
                ST_ACQUIRE: begin
                    if (w_good) begin
                        if (w_run_inc == 4'(LOCK_N)) begin
                            r_state  <= ST_LOCKED;
                            r_run    <= '0;
                            r_locked <= 1'b1;
                        end else begin
                            r_run <= w_run_inc;
                        end
                    end else if (r_have_prev) begin
                        r_run <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_good) begin
                        r_wrap <= (r_prev == '0);
                    end else begin
                        r_seq_err <= 1'b1;
                        r_run     <= '0;
                        r_locked  <= 1'b0;
                        if (w_err_next >= CNT_W'(ERR_LIMIT)) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state <= ST_ACQUIRE;
                        end
                    end
                end
                ST_FAULT: begin
                end
                default: begin
                    r_state <= ST_ACQUIRE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_en  (w_err_evt),
        .o_cnt (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_en  (w_wrap_evt),
        .o_cnt (wrap_cnt)
    );

    assign locked  = r_locked;
    assign fault   = r_fault;
    assign seq_err = r_seq_err;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_down_count_checker.sv
// Scoreboarded bench: directed scenarios plus a random walk, checked against a behavioural model.
module tb_down_count_checker;

    localparam int WIDTH     = 3;
    localparam int LOCK_N    = 4;
    localparam int ERR_LIMIT = 3;
    localparam int M         = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] count = '0;
    logic             locked, fault, seq_err, wrap;
    logic [7:0]       err_cnt, wrap_cnt;

    down_count_checker #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .count    (count),
        .locked   (locked),
        .fault    (fault),
        .seq_err  (seq_err),
        .wrap     (wrap),
        .err_cnt  (err_cnt),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tgt;
        int locked;
        int fault;
        int seq_err;
        int wrap;
        int err_cnt;
        int wrap_cnt;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Model: 0 = hunting for lock, 1 = locked, 2 = faulted
    int m_mode = 0, m_last = 0, m_have = 0, m_streak = 0, m_errs = 0, m_wraps = 0;
    int drv_last = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_and_push(bit r, int v);
        exp_t e;
        int   s_err = 0, s_wrap = 0;
        bit   good;
        if (r) begin
            m_mode = 0; m_last = 0; m_have = 0; m_streak = 0; m_errs = 0; m_wraps = 0;
        end else begin
            good = (m_have != 0) && (v == (m_last + M - 1) % M);
            if (m_mode == 0) begin
                if (good) begin
                    m_streak++;
                    if (m_streak == LOCK_N) begin
                        m_mode   = 1;
                        m_streak = 0;
                    end
                end else if (m_have != 0) begin
                    m_streak = 0;
                end
            end else if (m_mode == 1) begin
                if (good) begin
                    if (m_last == 0) begin
                        s_wrap  = 1;
                        m_wraps = (m_wraps < 255) ? m_wraps + 1 : 255;
                    end
                end else begin
                    s_err    = 1;
                    m_errs   = (m_errs < 255) ? m_errs + 1 : 255;
                    m_streak = 0;
                    m_mode   = (m_errs >= ERR_LIMIT) ? 2 : 0;
                end
            end
            m_last = v;
            m_have = 1;
        end
        e.tgt      = cyc + 1;
        e.locked   = (m_mode == 1) ? 1 : 0;
        e.fault    = (m_mode == 2) ? 1 : 0;
        e.seq_err  = s_err;
        e.wrap     = s_wrap;
        e.err_cnt  = m_errs;
        e.wrap_cnt = m_wraps;
        q.push_back(e);
    endtask

    task automatic step(bit r, int v);
        @(posedge clk);
        #1;
        rst      = r;
        count    = WIDTH'(v);
        drv_last = v;
        model_and_push(r, v);
    endtask

    task automatic run_down(int start, int n);
        for (int i = 0; i < n; i++) step(1'b0, ((start - i) % M + M) % M);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tgt <= cyc) begin
                e = q.pop_front();
                chk("order", e.tgt, cyc);
                chk("locked",   int'(locked),   e.locked);
                chk("fault",    int'(fault),    e.fault);
                chk("seq_err",  int'(seq_err),  e.seq_err);
                chk("wrap",     int'(wrap),     e.wrap);
                chk("err_cnt",  int'(err_cnt),  e.err_cnt);
                chk("wrap_cnt", int'(wrap_cnt), e.wrap_cnt);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin : stim
        int v;
        step(1'b1, 0);
        step(1'b1, 0);
        run_down(7, 5);
        run_down(2, 4);
        run_down(6, 3);
        run_down(6, 5);
        run_down(1, 2);
        run_down(4, 5);
        run_down(3, 2);
        run_down(6, 5);
        run_down(5, 10);
        for (int i = 0; i < 10; i++) step(1'b0, $urandom_range(0, M - 1));

        step(1'b1, 5);
        for (int i = 0; i < 20; i++) step(1'b0, 5);

        step(1'b1, 0);
        run_down(7, 17);
        run_down(3, 5);
        run_down(6, 2);
        step(1'b1, 4);
        run_down(7, 5);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                step(1'b1, $urandom_range(0, M - 1));
            end else begin
                if ($urandom_range(0, 9) < 9) v = (drv_last + M - 1) % M;
                else v = $urandom_range(0, M - 1);
                step(1'b0, v);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
